// File: rtl/router_reg_block.sv
// router_reg_block
//   Datapath register stage between the router control FSM and the output
//   FIFOs. Latches the packet header, steers header/payload/parity bytes onto
//   the FIFO write bus under FSM state strobes, parks the byte that arrives
//   while the FIFO is full, and tracks byte-wise XOR parity.
//
// Ports
//   clock            in   system clock, rising edge
//   resetn           in   synchronous active-low reset
//   pkt_valid        in   source byte valid (low on the parity byte)
//   data_in          in   source byte: header, payload..., parity
//   fifo_full        in   selected destination FIFO full
//   detect_add       in   FSM in decode_address
//   lfd_state        in   FSM in load_first_data
//   ld_state         in   FSM in load_data
//   laf_state        in   FSM in load_after_full
//   full_state       in   FSM in fifo_full_state
//   rst_int_reg      in   FSM in check_parity_error
//   dout             out  byte to FIFO write port (one cycle after strobe)
//   parity_done      out  parity byte consumed for current packet
//   low_packet_valid out  pkt_valid fell while in load_data
//   err              out  parity mismatch for the last packet
module router_reg_block #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_packet_valid,
    output logic             err
);

    logic [WIDTH-1:0] header_byte;
    logic [WIDTH-1:0] hold_byte;
    logic [WIDTH-1:0] internal_parity;
    logic [WIDTH-1:0] packet_parity;

    // full_state only marks the stall; dout simply holds through it.
    logic unused_full_state;
    assign unused_full_state = full_state;

    // Address 2'b11 is not a valid destination, so such a header is ignored.
    always_ff @(posedge clock) begin
        if (!resetn)
            header_byte <= '0;
        else if (detect_add && pkt_valid && data_in[1:0] != 2'b11)
            header_byte <= data_in;
    end

    // Write-bus steering. A byte that arrives while the FIFO is full is parked
    // in hold_byte and replayed in load_after_full.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout      <= '0;
            hold_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    // Running parity includes stalled bytes too: they belong to the packet
    // even though they reach the FIFO later via hold_byte.
    always_ff @(posedge clock) begin
        if (!resetn)
            internal_parity <= '0;
        else if (detect_add)
            internal_parity <= '0;
        else if (lfd_state)
            internal_parity <= internal_parity ^ header_byte;
        else if (ld_state && pkt_valid)
            internal_parity <= internal_parity ^ data_in;
    end

    // The byte seen in load_data with pkt_valid low is the parity byte.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            packet_parity    <= '0;
            low_packet_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            packet_parity    <= data_in;
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end
    end

    // Parity byte is consumed either directly, or on replay after a stall
    // (low_packet_valid tells a stalled parity byte from a stalled payload).
    always_ff @(posedge clock) begin
        if (!resetn)
            parity_done <= 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_packet_valid && !parity_done))
            parity_done <= 1'b1;
        else if (detect_add)
            parity_done <= 1'b0;
    end

    // err is sticky past packet end so the host can sample it late.
    always_ff @(posedge clock) begin
        if (!resetn)
            err <= 1'b0;
        else if (rst_int_reg)
            err <= (internal_parity != packet_parity);
        else if (detect_add && pkt_valid)
            err <= 1'b0;
    end

endmodule

// File: tb/tb_router_reg_block.sv
module tb_router_reg_block;

    localparam int W   = 8;
    localparam int DA  = 1;
    localparam int LFD = 2;
    localparam int LD  = 4;
    localparam int LAF = 8;
    localparam int FS  = 16;
    localparam int RIR = 32;
    localparam int RST = 64;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         fifo_full = 1'b0;
    logic         detect_add = 1'b0;
    logic         lfd_state = 1'b0;
    logic         ld_state = 1'b0;
    logic         laf_state = 1'b0;
    logic         full_state = 1'b0;
    logic         rst_int_reg = 1'b0;
    logic [W-1:0] dout;
    logic         parity_done;
    logic         low_packet_valid;
    logic         err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        int         op;
        logic       pv;
        logic       ff;
        logic [7:0] e_dout;
        logic       e_pd;
        logic       e_lpv;
        logic       e_err;
    } row_t;

    typedef struct {
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
    } exp_t;

    exp_t sbq[$];

    always #5 clock = ~clock;

    router_reg_block #(.WIDTH(W)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    function automatic row_t mk(input logic [7:0] d, input int op, input logic pv, input logic ff,
                                input logic [7:0] ed, input logic epd, input logic elpv, input logic eerr);
        row_t r;
        r.d = d; r.op = op; r.pv = pv; r.ff = ff;
        r.e_dout = ed; r.e_pd = epd; r.e_lpv = elpv; r.e_err = eerr;
        return r;
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic apply(input row_t r);
        exp_t e;
        data_in     = r.d;
        pkt_valid   = r.pv;
        fifo_full   = r.ff;
        detect_add  = (r.op & DA)  != 0;
        lfd_state   = (r.op & LFD) != 0;
        ld_state    = (r.op & LD)  != 0;
        laf_state   = (r.op & LAF) != 0;
        full_state  = (r.op & FS)  != 0;
        rst_int_reg = (r.op & RIR) != 0;
        resetn      = (r.op & RST) == 0;
        e.dout = r.e_dout; e.pd = r.e_pd; e.lpv = r.e_lpv; e.err = r.e_err;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        row_t r[$];
        r.push_back(mk(8'hA5, RST | LD, 1, 0, 8'h00, 0, 0, 0));
        r.push_back(mk(8'h5A, RST | LFD, 0, 0, 8'h00, 0, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL reset[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL reset[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL reset[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL reset[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    // 05 ^ A1 ^ 3C = 98
    task automatic test_normal();
        row_t r[$];
        r.push_back(mk(8'h05, DA,  1, 0, 8'h00, 0, 0, 0));
        r.push_back(mk(8'hA1, LFD, 1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'hA1, LD,  1, 0, 8'hA1, 0, 0, 0));
        r.push_back(mk(8'h3C, LD,  1, 0, 8'h3C, 0, 0, 0));
        r.push_back(mk(8'h98, LD,  0, 0, 8'h98, 1, 1, 0));
        r.push_back(mk(8'h00, RIR, 0, 0, 8'h98, 1, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL normal[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL normal[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL normal[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL normal[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    task automatic test_bad_parity();
        row_t r[$];
        r.push_back(mk(8'h05, DA,  1, 0, 8'h98, 0, 0, 0));
        r.push_back(mk(8'hA1, LFD, 1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'hA1, LD,  1, 0, 8'hA1, 0, 0, 0));
        r.push_back(mk(8'h3C, LD,  1, 0, 8'h3C, 0, 0, 0));
        r.push_back(mk(8'h99, LD,  0, 0, 8'h99, 1, 1, 0));
        r.push_back(mk(8'h00, RIR, 0, 0, 8'h99, 1, 0, 1));
        r.push_back(mk(8'h00, 0,   0, 0, 8'h99, 1, 0, 1));
        r.push_back(mk(8'h06, DA,  0, 0, 8'h99, 0, 0, 1));
        r.push_back(mk(8'h05, DA,  1, 0, 8'h99, 0, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL bad_parity[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL bad_parity[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL bad_parity[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL bad_parity[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    task automatic test_full_payload();
        row_t r[$];
        r.push_back(mk(8'h05, DA,  1, 0, 8'h99, 0, 0, 0));
        r.push_back(mk(8'hA1, LFD, 1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'hA1, LD,  1, 1, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h3C, FS,  1, 1, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h3C, LAF, 1, 0, 8'hA1, 0, 0, 0));
        r.push_back(mk(8'h3C, LD,  1, 0, 8'h3C, 0, 0, 0));
        r.push_back(mk(8'h98, LD,  0, 0, 8'h98, 1, 1, 0));
        r.push_back(mk(8'h00, RIR, 0, 0, 8'h98, 1, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL full_payload[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL full_payload[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL full_payload[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL full_payload[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    task automatic test_full_parity();
        row_t r[$];
        r.push_back(mk(8'h05, DA,  1, 0, 8'h98, 0, 0, 0));
        r.push_back(mk(8'hA1, LFD, 1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'hA1, LD,  1, 0, 8'hA1, 0, 0, 0));
        r.push_back(mk(8'h3C, LD,  1, 0, 8'h3C, 0, 0, 0));
        r.push_back(mk(8'h98, LD,  0, 1, 8'h3C, 0, 1, 0));
        r.push_back(mk(8'h00, FS,  0, 1, 8'h3C, 0, 1, 0));
        r.push_back(mk(8'h00, LAF, 0, 0, 8'h98, 1, 1, 0));
        r.push_back(mk(8'h00, RIR, 0, 0, 8'h98, 1, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL full_parity[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL full_parity[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL full_parity[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL full_parity[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    // Builds up nonzero dout/parity_done/low_packet_valid/err, resets with
    // ld_state asserted, then runs a good packet: 06 ^ 11 ^ 22 = 35.
    task automatic test_reset_mid();
        row_t r[$];
        r.push_back(mk(8'h05, DA,       1, 0, 8'h98, 0, 0, 0));
        r.push_back(mk(8'hA1, LFD,      1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'hA1, LD,       1, 0, 8'hA1, 0, 0, 0));
        r.push_back(mk(8'h3C, LD,       0, 0, 8'h3C, 1, 1, 0));
        r.push_back(mk(8'h00, RIR,      0, 0, 8'h3C, 1, 0, 1));
        r.push_back(mk(8'h77, LD,       0, 0, 8'h77, 1, 1, 1));
        r.push_back(mk(8'hA5, RST | LD, 1, 0, 8'h00, 0, 0, 0));
        r.push_back(mk(8'h5A, LD,       1, 0, 8'h5A, 0, 0, 0));
        r.push_back(mk(8'h00, LFD,      1, 0, 8'h00, 0, 0, 0));
        r.push_back(mk(8'h06, DA,       1, 0, 8'h00, 0, 0, 0));
        r.push_back(mk(8'h11, LFD,      1, 0, 8'h06, 0, 0, 0));
        r.push_back(mk(8'h11, LD,       1, 0, 8'h11, 0, 0, 0));
        r.push_back(mk(8'h22, LD,       1, 0, 8'h22, 0, 0, 0));
        r.push_back(mk(8'h35, LD,       0, 0, 8'h35, 1, 1, 0));
        r.push_back(mk(8'h00, RIR,      0, 0, 8'h35, 1, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL reset_mid[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL reset_mid[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL reset_mid[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL reset_mid[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    // Invalid address 2'b11 leaves header_byte alone; also strobe priority.
    task automatic test_bad_addr();
        row_t r[$];
        r.push_back(mk(8'h05, DA,        1, 0, 8'h35, 0, 0, 0));
        r.push_back(mk(8'h5A, LD,        1, 0, 8'h5A, 0, 0, 0));
        r.push_back(mk(8'h07, DA,        1, 0, 8'h5A, 0, 0, 0));
        r.push_back(mk(8'h00, LFD,       1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h0B, DA,        1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h5A, LD,        1, 0, 8'h5A, 0, 0, 0));
        r.push_back(mk(8'h00, LFD,       1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h02, DA,        1, 0, 8'h05, 0, 0, 0));
        r.push_back(mk(8'h00, LFD,       1, 0, 8'h02, 0, 0, 0));
        r.push_back(mk(8'h99, LFD | LD,  1, 0, 8'h02, 0, 0, 0));
        r.push_back(mk(8'h44, LD | LAF,  1, 0, 8'h44, 0, 0, 0));
        r.push_back(mk(8'h55, LD | LAF,  1, 1, 8'h44, 0, 0, 0));
        r.push_back(mk(8'h00, LAF,       1, 0, 8'h55, 0, 0, 0));
        foreach (r[i]) begin
            exp_t e;
            apply(r[i]); tick(); e = sbq.pop_front();
            total += 4;
            if (dout !== e.dout) begin bad++; $display("FAIL bad_addr[%0d].dout got=%h want=%h", i, dout, e.dout); end
            if (parity_done !== e.pd) begin bad++; $display("FAIL bad_addr[%0d].parity_done got=%b want=%b", i, parity_done, e.pd); end
            if (low_packet_valid !== e.lpv) begin bad++; $display("FAIL bad_addr[%0d].low_packet_valid got=%b want=%b", i, low_packet_valid, e.lpv); end
            if (err !== e.err) begin bad++; $display("FAIL bad_addr[%0d].err got=%b want=%b", i, err, e.err); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_parity();
        test_full_payload();
        test_full_parity();
        test_reset_mid();
        test_bad_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
